// File: rtl/sudoku_cell_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// sudoku_cell_fetch_ctrl
//
// Purpose:
//   Follows the VGA scan over the 9x9 Sudoku grid and keeps a "current cell"
//   buffer that feeds Number_Pixel_Gen. While the scan is inside one cell, the
//   digit of the next cell is prefetched from the single-port board RAM into a
//   "next cell" buffer. The buffer is swapped in when the scan crosses into
//   that cell. Game-logic writes share the RAM port and have lower priority
//   than display prefetch. Writes that hit a buffered cell also update the
//   buffer, so the display never shows a stale digit.
//
// Ports:
//   clk, rst_n            pixel clock, synchronous active-low reset
//   h_cnt, v_cnt          current scan column / line
//   pixel_valid           active-video qualifier
//   wr_req/wr_index/
//   wr_number             game-logic write request (held until wr_ack)
//   wr_ack                one-cycle pulse in the cycle the write is issued
//   ram_addr/ram_we/
//   ram_wdata/ram_rdata   board RAM port (read data valid 1 cycle after addr)
//   disp_index/disp_number/
//   disp_valid            current cell towards Number_Pixel_Gen
//   underrun              sticky flag: a cell was entered before its digit
//                         had been fetched
// -----------------------------------------------------------------------------
module sudoku_cell_fetch_ctrl #(
    parameter int CELL_SIZE = 52,
    parameter int GRID      = 9,
    parameter int LEAD      = 4,
    parameter int V_TOTAL   = 525
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        pixel_valid,
    input  logic        wr_req,
    input  logic [6:0]  wr_index,
    input  logic [10:0] wr_number,
    output logic        wr_ack,
    output logic [6:0]  ram_addr,
    output logic        ram_we,
    output logic [10:0] ram_wdata,
    input  logic [10:0] ram_rdata,
    output logic [9:0]  disp_index,
    output logic [10:0] disp_number,
    output logic        disp_valid,
    output logic        underrun
);

    localparam logic [9:0]  GRID_PIX  = 10'(GRID * CELL_SIZE);
    localparam logic [9:0]  CELL_PIX  = 10'(CELL_SIZE);
    localparam logic [9:0]  TRIG_LX   = 10'(CELL_SIZE - LEAD);
    localparam logic [9:0]  LAST_COL  = 10'(GRID - 1);
    localparam logic [9:0]  LAST_LINE = 10'(V_TOTAL - 1);
    localparam logic [9:0]  GRID_W    = 10'(GRID);
    localparam logic [10:0] BLANK     = 11'h400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        RD_WAIT = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;

    logic        fetch_pending_r, fetch_pending_nxt_s;
    logic [6:0]  fetch_index_r, fetch_index_nxt_s;

    logic [10:0] cur_number_r, cur_number_nxt_s;
    logic [6:0]  cur_index_r, cur_index_nxt_s;
    logic        cur_valid_r, cur_valid_nxt_s;
    logic [10:0] next_number_r, next_number_nxt_s;
    logic [6:0]  next_index_r, next_index_nxt_s;
    logic        next_valid_r, next_valid_nxt_s;
    logic        underrun_r, underrun_nxt_s;

    logic [6:0]  ram_addr_r, ram_addr_nxt_s;
    logic        ram_we_r, ram_we_nxt_s;
    logic [10:0] ram_wdata_r, ram_wdata_nxt_s;
    logic        wr_ack_r, wr_ack_nxt_s;

    logic [9:0]  disp_index_r;
    logic [10:0] disp_number_r;
    logic        disp_valid_r;

    logic [9:0]  col_s, row_s, lx_s, next_line_s, next_row_s;
    logic        in_grid_s, swap_s, trig_s, wr_active_s;
    logic [6:0]  cell_index_s, trig_index_s;

    // Scan position decode: cell coordinates, position inside the cell.
    always_comb begin
        col_s        = h_cnt / CELL_PIX;
        row_s        = v_cnt / CELL_PIX;
        lx_s         = h_cnt % CELL_PIX;
        in_grid_s    = pixel_valid && (h_cnt < GRID_PIX) && (v_cnt < GRID_PIX);
        cell_index_s = 7'(row_s * GRID_W + col_s);
        next_line_s  = (v_cnt == LAST_LINE) ? 10'd0 : (v_cnt + 10'd1);
        next_row_s   = next_line_s / CELL_PIX;
        swap_s       = in_grid_s && (lx_s == 10'd0);
    end

    // Prefetch trigger: LEAD pixels before a cell ends, or just past the grid's
    // right edge for column 0 of the following line.
    always_comb begin
        trig_s       = 1'b0;
        trig_index_s = 7'd0;
        if (in_grid_s && (lx_s == TRIG_LX) && (col_s < LAST_COL)) begin
            trig_s       = 1'b1;
            trig_index_s = cell_index_s + 7'd1;
        end else if ((h_cnt == GRID_PIX) && (next_line_s < GRID_PIX)) begin
            trig_s       = 1'b1;
            trig_index_s = 7'(next_row_s * GRID_W);
        end else begin
            trig_s       = 1'b0;
        end
    end

    // RAM port FSM next state and registered port values. A trigger seen in
    // IDLE is acted on at once so the fetch wins over a same-cycle write.
    always_comb begin
        state_nxt_s         = state_r;
        fetch_pending_nxt_s = fetch_pending_r;
        fetch_index_nxt_s   = fetch_index_r;
        ram_addr_nxt_s      = ram_addr_r;
        ram_wdata_nxt_s     = ram_wdata_r;
        ram_we_nxt_s        = 1'b0;
        wr_ack_nxt_s        = 1'b0;

        case (state_r)
            IDLE: begin
                if (trig_s || fetch_pending_r) begin
                    state_nxt_s = RD;
                end else if (wr_req) begin
                    state_nxt_s = WR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD:      state_nxt_s = RD_WAIT;
            RD_WAIT: state_nxt_s = IDLE;
            WR:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase

        // A trigger arriving while busy stays pending until the next IDLE.
        if (trig_s) begin
            fetch_pending_nxt_s = 1'b1;
            fetch_index_nxt_s   = trig_index_s;
        end else if (state_r == RD) begin
            fetch_pending_nxt_s = 1'b0;
        end else begin
            fetch_pending_nxt_s = fetch_pending_r;
        end

        if (state_nxt_s == RD) begin
            ram_addr_nxt_s = trig_s ? trig_index_s : fetch_index_r;
        end else if (state_nxt_s == WR) begin
            ram_addr_nxt_s  = wr_index;
            ram_wdata_nxt_s = wr_number;
            ram_we_nxt_s    = 1'b1;
            wr_ack_nxt_s    = 1'b1;
        end else begin
            ram_we_nxt_s    = 1'b0;
        end
    end

    // Cell buffers: write coherency, swap on cell entry, read-data capture.
    always_comb begin
        wr_active_s       = (state_r == WR);
        cur_number_nxt_s  = cur_number_r;
        cur_index_nxt_s   = cur_index_r;
        cur_valid_nxt_s   = cur_valid_r;
        next_number_nxt_s = next_number_r;
        next_index_nxt_s  = next_index_r;
        next_valid_nxt_s  = next_valid_r;
        underrun_nxt_s    = underrun_r;

        // Patch the next buffer first so a swap in the same cycle carries
        // the freshly written digit.
        if (wr_active_s && next_valid_r && (ram_addr_r == next_index_r)) begin
            next_number_nxt_s = ram_wdata_r;
        end else begin
            next_number_nxt_s = next_number_r;
        end

        if (swap_s) begin
            if (next_valid_r) begin
                cur_number_nxt_s = next_number_nxt_s;
                cur_index_nxt_s  = next_index_r;
                cur_valid_nxt_s  = 1'b1;
                next_valid_nxt_s = 1'b0;
            end else begin
                cur_number_nxt_s = BLANK;
                cur_index_nxt_s  = cell_index_s;
                cur_valid_nxt_s  = 1'b1;
                underrun_nxt_s   = 1'b1;
            end
        end else if (!in_grid_s) begin
            cur_valid_nxt_s = 1'b0;
        end else begin
            cur_valid_nxt_s = cur_valid_r;
        end

        if (wr_active_s && cur_valid_nxt_s && (ram_addr_r == cur_index_nxt_s)) begin
            cur_number_nxt_s = ram_wdata_r;
        end else begin
            cur_number_nxt_s = cur_number_nxt_s;
        end

        if (state_r == RD_WAIT) begin
            next_number_nxt_s = ram_rdata;
            next_index_nxt_s  = ram_addr_r;
            next_valid_nxt_s  = 1'b1;
        end else begin
            next_valid_nxt_s  = next_valid_nxt_s;
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            fetch_pending_r <= 1'b0;
            fetch_index_r   <= 7'd0;
            cur_number_r    <= BLANK;
            cur_index_r     <= 7'd0;
            cur_valid_r     <= 1'b0;
            next_number_r   <= BLANK;
            next_index_r    <= 7'd0;
            next_valid_r    <= 1'b0;
            underrun_r      <= 1'b0;
            ram_addr_r      <= 7'd0;
            ram_we_r        <= 1'b0;
            ram_wdata_r     <= BLANK;
            wr_ack_r        <= 1'b0;
            disp_index_r    <= 10'd0;
            disp_number_r   <= BLANK;
            disp_valid_r    <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            fetch_pending_r <= fetch_pending_nxt_s;
            fetch_index_r   <= fetch_index_nxt_s;
            cur_number_r    <= cur_number_nxt_s;
            cur_index_r     <= cur_index_nxt_s;
            cur_valid_r     <= cur_valid_nxt_s;
            next_number_r   <= next_number_nxt_s;
            next_index_r    <= next_index_nxt_s;
            next_valid_r    <= next_valid_nxt_s;
            underrun_r      <= underrun_nxt_s;
            ram_addr_r      <= ram_addr_nxt_s;
            ram_we_r        <= ram_we_nxt_s;
            ram_wdata_r     <= ram_wdata_nxt_s;
            wr_ack_r        <= wr_ack_nxt_s;
            disp_index_r    <= {3'b000, cur_index_nxt_s};
            disp_number_r   <= in_grid_s ? cur_number_nxt_s : BLANK;
            disp_valid_r    <= in_grid_s && cur_valid_nxt_s;
        end
    end

    assign ram_addr    = ram_addr_r;
    assign ram_we      = ram_we_r;
    assign ram_wdata   = ram_wdata_r;
    assign wr_ack      = wr_ack_r;
    assign disp_index  = disp_index_r;
    assign disp_number = disp_number_r;
    assign disp_valid  = disp_valid_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_sudoku_cell_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sudoku_cell_fetch_ctrl
//
// Directed bench for sudoku_cell_fetch_ctrl. Each scan step pushes its
// expected outputs into a queue; after the clock edge the queue is drained
// and every entry is compared against the DUT. A small board-RAM model
// answers reads one cycle after the address and absorbs writes.
// -----------------------------------------------------------------------------
module tb_sudoku_cell_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        pixel_valid;
    logic        wr_req;
    logic [6:0]  wr_index;
    logic [10:0] wr_number;
    logic        wr_ack;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [10:0] ram_wdata;
    logic [10:0] ram_rdata;
    logic [9:0]  disp_index;
    logic [10:0] disp_number;
    logic        disp_valid;
    logic        underrun;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    int we_cnt   = 0;

    localparam int S_WE    = 0;
    localparam int S_ACK   = 1;
    localparam int S_ADDR  = 2;
    localparam int S_WDATA = 3;
    localparam int S_DIDX  = 4;
    localparam int S_DNUM  = 5;
    localparam int S_DVAL  = 6;
    localparam int S_UND   = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    logic [10:0] mem     [0:80];
    logic        written [0:80] = '{default: 1'b0};

    sudoku_cell_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .pixel_valid (pixel_valid),
        .wr_req      (wr_req),
        .wr_index    (wr_index),
        .wr_number   (wr_number),
        .wr_ack      (wr_ack),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .disp_index  (disp_index),
        .disp_number (disp_number),
        .disp_valid  (disp_valid),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board contents before any write: one-hot digit, cell 9 made distinct.
    function automatic logic [10:0] init_val(input logic [6:0] idx);
        logic [10:0] one;
        int          sh;
        one = 11'h001;
        sh  = (int'(idx) + 1) % 9;
        if (idx == 7'd9) return 11'h100;
        else             return one << sh;
    endfunction

    // Board RAM model: registered read, write on ram_we.
    always @(posedge clk) begin
        if (ram_addr <= 7'd80) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end
            ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
        end else begin
            ram_rdata <= 11'h000;
        end
    end

    // Pulse counters for write handshake.
    always @(posedge clk) begin
        if (wr_ack) ack_cnt <= ack_cnt + 1;
        if (ram_we) we_cnt  <= we_cnt + 1;
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_WE:    return {31'd0, ram_we};
            S_ACK:   return {31'd0, wr_ack};
            S_ADDR:  return {25'd0, ram_addr};
            S_WDATA: return {21'd0, ram_wdata};
            S_DIDX:  return {22'd0, disp_index};
            S_DNUM:  return {21'd0, disp_number};
            S_DVAL:  return {31'd0, disp_valid};
            S_UND:   return {31'd0, underrun};
            default: return 32'hffff_ffff;
        endcase
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic expect_disp(input string tag, input logic [9:0] idx,
                               input logic [10:0] num, input logic vld);
        expect_out({tag, "_idx"}, S_DIDX, {22'd0, idx});
        expect_out({tag, "_num"}, S_DNUM, {21'd0, num});
        expect_out({tag, "_val"}, S_DVAL, {31'd0, vld});
    endtask

    // Drive one scan position, clock it, then drain the scoreboard.
    task automatic tick(input logic [9:0] h, input logic [9:0] v);
        exp_t e;
        h_cnt = h;
        v_cnt = v;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            compare(e.tag, observe(e.sel), e.exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        h_cnt       = 10'd600;
        v_cnt       = 10'd500;
        pixel_valid = 1'b1;
        wr_req      = 1'b0;
        wr_index    = 7'd0;
        wr_number   = 11'h400;

        // Reset values.
        tick(10'd600, 10'd500);
        expect_out("rst_we", S_WE, 32'd0);
        expect_out("rst_ack", S_ACK, 32'd0);
        expect_out("rst_und", S_UND, 32'd0);
        expect_disp("rst", 10'd0, 11'h400, 1'b0);
        tick(10'd600, 10'd500);

        // Start a fetch, then reset while it is in RD.
        rst_n = 1'b1;
        expect_out("mid_rd_addr", S_ADDR, 32'd0);
        expect_out("mid_rd_we", S_WE, 32'd0);
        tick(10'd468, 10'd524);
        rst_n     = 1'b0;
        wr_req    = 1'b1;
        wr_index  = 7'd3;
        wr_number = 11'h008;
        for (int i = 0; i < 3; i++) begin
            expect_out("rrd_we", S_WE, 32'd0);
            expect_out("rrd_ack", S_ACK, 32'd0);
            expect_out("rrd_und", S_UND, 32'd0);
            expect_disp("rrd", 10'd0, 11'h400, 1'b0);
            tick(10'(469 + i), 10'd524);
        end

        // FSM left in IDLE: held write is issued right after reset release.
        rst_n = 1'b1;
        expect_out("post_rst_we", S_WE, 32'd1);
        expect_out("post_rst_ack", S_ACK, 32'd1);
        expect_out("post_rst_addr", S_ADDR, 32'd3);
        expect_out("post_rst_wdata", S_WDATA, 32'h008);
        tick(10'd600, 10'd500);
        wr_req = 1'b0;
        expect_out("post_rst_we_off", S_WE, 32'd0);
        expect_out("post_rst_ack_off", S_ACK, 32'd0);
        tick(10'd600, 10'd500);

        // Prefetch cell 0 at end of last line, then scan row 0.
        expect_out("pre0_addr", S_ADDR, 32'd0);
        tick(10'd468, 10'd524);
        tick(10'd469, 10'd524);
        tick(10'd470, 10'd524);
        expect_disp("cell0", 10'd0, 11'h002, 1'b1);
        expect_out("cell0_und", S_UND, 32'd0);
        tick(10'd0, 10'd0);
        for (int i = 1; i < 48; i++) tick(10'(i), 10'd0);
        expect_out("trig48_addr", S_ADDR, 32'd1);
        expect_out("trig48_we", S_WE, 32'd0);
        tick(10'd48, 10'd0);
        tick(10'd49, 10'd0);
        tick(10'd50, 10'd0);
        tick(10'd51, 10'd0);
        expect_disp("cell1", 10'd1, 11'h004, 1'b1);
        expect_out("cell1_und", S_UND, 32'd0);
        tick(10'd52, 10'd0);

        // Line wrap into row 1, then frame wrap to row 0.
        expect_out("wrap9_addr", S_ADDR, 32'd9);
        expect_disp("outgrid", 10'd1, 11'h400, 1'b0);
        tick(10'd468, 10'd51);
        tick(10'd469, 10'd51);
        tick(10'd470, 10'd51);
        expect_disp("cell9", 10'd9, 11'h100, 1'b1);
        tick(10'd0, 10'd52);
        expect_out("wrap0_addr", S_ADDR, 32'd0);
        tick(10'd468, 10'd524);
        tick(10'd469, 10'd524);
        tick(10'd470, 10'd524);

        // Contention: write request in the trigger cycle.
        expect_disp("cont_cell0", 10'd0, 11'h002, 1'b1);
        tick(10'd0, 10'd0);
        tick(10'd44, 10'd0);
        wr_req    = 1'b1;
        wr_index  = 7'd40;
        wr_number = 11'h200;
        expect_out("cont_rd_addr", S_ADDR, 32'd1);
        expect_out("cont_we0", S_WE, 32'd0);
        expect_out("cont_ack0", S_ACK, 32'd0);
        tick(10'd48, 10'd0);
        expect_out("cont_we1", S_WE, 32'd0);
        tick(10'd49, 10'd0);
        expect_out("cont_we2", S_WE, 32'd0);
        tick(10'd50, 10'd0);
        expect_out("cont_we3", S_WE, 32'd1);
        expect_out("cont_ack3", S_ACK, 32'd1);
        expect_out("cont_wr_addr", S_ADDR, 32'd40);
        expect_out("cont_wdata", S_WDATA, 32'h200);
        tick(10'd51, 10'd0);
        wr_req = 1'b0;
        expect_out("cont_we_off", S_WE, 32'd0);
        expect_out("cont_ack_off", S_ACK, 32'd0);
        expect_disp("cont_cell1", 10'd1, 11'h004, 1'b1);
        expect_out("cont_und", S_UND, 32'd0);
        tick(10'd52, 10'd0);

        // Coherency: write into the prefetched next cell before the swap.
        expect_out("coh_rd_addr", S_ADDR, 32'd5);
        tick(10'd256, 10'd0);
        tick(10'd257, 10'd0);
        tick(10'd258, 10'd0);
        wr_req    = 1'b1;
        wr_index  = 7'd5;
        wr_number = 11'h002;
        expect_out("coh_next_we", S_WE, 32'd1);
        expect_out("coh_next_addr", S_ADDR, 32'd5);
        tick(10'd259, 10'd0);
        wr_req = 1'b0;
        expect_out("coh_hold_idx", S_DIDX, 32'd1);
        tick(10'd259, 10'd0);
        expect_disp("coh_swap", 10'd5, 11'h002, 1'b1);
        tick(10'd260, 10'd0);

        // Coherency: write to the cell currently on display.
        wr_req    = 1'b1;
        wr_number = 11'h080;
        expect_out("coh_cur_we", S_WE, 32'd1);
        expect_out("coh_cur_before", S_DNUM, 32'h002);
        tick(10'd261, 10'd0);
        wr_req = 1'b0;
        expect_out("coh_cur_after", S_DNUM, 32'h080);
        expect_out("coh_cur_we_off", S_WE, 32'd0);
        tick(10'd262, 10'd0);

        // Starvation: skip the trigger pixel so cell 6 is entered unfetched.
        tick(10'd300, 10'd0);
        pixel_valid = 1'b0;
        tick(10'd310, 10'd0);
        pixel_valid = 1'b1;
        tick(10'd311, 10'd0);
        expect_disp("starve", 10'd6, 11'h400, 1'b1);
        expect_out("starve_und", S_UND, 32'd1);
        tick(10'd312, 10'd0);
        expect_out("sticky_und1", S_UND, 32'd1);
        tick(10'd600, 10'd500);
        expect_out("sticky_und2", S_UND, 32'd1);
        expect_disp("sticky_out", 10'd6, 11'h400, 1'b0);
        tick(10'd600, 10'd500);
        rst_n = 1'b0;
        expect_out("final_rst_und", S_UND, 32'd0);
        tick(10'd600, 10'd500);
        rst_n = 1'b1;
        expect_out("final_und", S_UND, 32'd0);
        tick(10'd600, 10'd500);
        tick(10'd600, 10'd500);

        // Each write produced exactly one ack and one write-enable cycle.
        compare("ack_pulses", 32'(ack_cnt), 32'd4);
        compare("we_pulses", 32'(we_cnt), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sudoku_cell_fetch_ctrl.md
Name: sudoku_cell_fetch_ctrl

Overview:
- Sequences the per-cell digit lookup that feeds Number_Pixel_Gen.
- Tracks the VGA scan position over the 9x9 grid of 52-pixel cells and prefetches the next cell's one-hot number from the board RAM before the scan reaches that cell.
- Arbitrates the single board-RAM port between display prefetch (priority) and game-logic writes.
- Keeps its current/next cell buffers coherent with writes.

Parameters:
- CELL_SIZE, 52, pixel width/height of one cell
- GRID, 9, cells per row/column; grid spans 0..GRID*CELL_SIZE-1 on both axes
- LEAD, 4, cycles before cell end at which the next cell's prefetch triggers
- V_TOTAL, 525, total lines per frame (v_cnt wrap)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- h_cnt  in  10  scan column
- v_cnt  in  10  scan line
- pixel_valid  in  1  active video
- wr_req  in  1  game-logic write request; held until wr_ack
- wr_index  in  7  cell 0..80 to write
- wr_number  in  11  one-hot digit; bit10 = blank
- wr_ack  out  1  one-cycle write-done pulse
- ram_addr  out  7  board RAM address
- ram_we  out  1  board RAM write enable
- ram_wdata  out  11  board RAM write data
- ram_rdata  in  11  read data, valid exactly 1 cycle after address
- disp_index  out  10  cell index to Number_Pixel_Gen
- disp_number  out  11  one-hot number to Number_Pixel_Gen
- disp_valid  out  1  scan inside grid with valid cur buffer
- underrun  out  1  sticky: cell entered without fetched data

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, cur/next number = 11'h400 (blank), cur/next index = 0, cur/next valid = 0, fetch-pending = 0, ram_we = 0, wr_ack = 0, underrun = 0, disp_valid = 0. Reset mid-transaction aborts it; no write is issued or acked.
- Position: col = h_cnt/CELL_SIZE, row = v_cnt/CELL_SIZE, lx = h_cnt%CELL_SIZE. In-grid when h_cnt, v_cnt < GRID*CELL_SIZE.
- Prefetch trigger, registered into fetch-pending with target index:
  - in-grid, lx == CELL_SIZE-LEAD, col < GRID-1 → row*GRID+col+1.
  - h_cnt == GRID*CELL_SIZE → col 0 of the next line's row. Next line = v_cnt+1, or 0 when v_cnt == V_TOTAL-1. No trigger if the next line is outside the grid.
- Swap: in-grid and lx == 0:
  - next_valid=1 → cur <= next, next_valid <= 0.
  - next_valid=0 → cur_number <= blank, cur_valid <= 1, underrun <= 1.
  - Leaving the grid clears cur_valid.
- Outputs (registered):
  - disp_index/disp_number = cur buffer.
  - disp_valid = in-grid & cur_valid.
  - Out of grid: disp_number = 11'h400.
- FSM:
  - IDLE: fetch-pending → RD. Else wr_req → WR. Else stay.
  - RD: ram_addr = fetch index, ram_we = 0, clear fetch-pending → RD_WAIT.
  - RD_WAIT: next_number <= ram_rdata, next_index <= fetch index, next_valid <= 1 → IDLE.
  - WR: ram_addr = wr_index, ram_wdata = wr_number, ram_we = 1, wr_ack = 1 for this cycle only → IDLE.
  - Worst-case fetch latency from trigger: 1 write + 2 read cycles ≤ LEAD.
- Simultaneity: a trigger and wr_req in the same IDLE cycle → fetch wins, write waits. A trigger during WR or RD_WAIT is held pending and serviced at the next IDLE.
- Coherency in the WR cycle:
  - wr_index == next_index & next_valid → next_number <= wr_number.
  - wr_index == cur_index & cur_valid → cur_number <= wr_number.
  - Visible on disp_number the following cycle.
- Widths: cell index is 7 bits internally, zero-extended to 10 on disp_index. row*GRID+col ≤ 80.

Test Plan:
- Reset: hold rst_n=0 3 cycles mid-RD → ram_we=0, wr_ack=0, disp_number=11'h400, underrun=0, FSM IDLE.
- Scan row 0 from h_cnt=0, RAM cell1=11'h004 → trigger at h_cnt=48, ram_addr=1 next cycle; at h_cnt=52, disp_index=1, disp_number=11'h004, disp_valid=1.
- Line wrap: v_cnt=51, h_cnt=468 → fetch of index 9. Then v_cnt=52, h_cnt=0 → disp_index=9. At v_cnt=524, h_cnt=468 → fetch of index 0.
- Contention: wr_req (idx 40, 11'h200) asserted in the trigger cycle → read first, ram_we=1 exactly 3 cycles after trigger, single wr_ack pulse, no underrun.
- Coherency: next buffer holds idx 5; write idx 5 = 11'h002 → at swap, disp_number=11'h002. Write to cur idx → disp_number updates 1 cycle after WR.
- Starvation: force RAM fetch blocked (pixel_valid toggled, trigger suppressed via h_cnt jump) → cell entry with next_valid=0 gives disp_number=11'h400 and underrun stays 1 until reset.
